pipelined_chunk_adder: RTL and testbench

- Parametrised, pipelined successor to the four-chunk 16-bit ripple adder.
- Splits a WIDTH-bit add into NCHUNK = WIDTH/CHUNK chunks and resolves one chunk per pipeline stage.
- Adds a subtract mode, a signed-overflow flag and valid/ready handshakes on both sides.
- Sits between operand producers and any consumer that needs a sum every cycle at high clock rate.

---
 rtl/adder_pkg.sv | 15 +
 rtl/chunk_add.sv | 24 ++
 rtl/pipelined_chunk_adder.sv | 116 +++++++++++
 tb/tb_pipelined_chunk_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined chunk adder: default geometry,
// the chunk-count helper and the add/subtract mode encoding.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit ripple adder built from full-adder cells; one
// instance resolves one chunk of the pipelined adder.
module chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// WIDTH-bit adder/subtractor resolving one CHUNK-bit slice per stage, with a
// single global advance enable shared by valid/ready on both sides.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      a,
  input  logic [WIDTH-1:0]                      b,
  input  logic                                  cIn,
  input  logic                                  sub,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      sum,
  output logic [calc_nchunk(WIDTH, CHUNK)-1:0]  cout_chunks,
  output logic                                  carry_out,
  output logic                                  overflow
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int MSB    = WIDTH - 1;

  // Level 0 holds freshly accepted operands; level k+1 holds the result of
  // chunk k, so level NCHUNK is the fully resolved sum.
  logic [WIDTH-1:0]  a_q   [0:NCHUNK];
  logic [WIDTH-1:0]  a_d   [0:NCHUNK];
  logic [WIDTH-1:0]  b_q   [0:NCHUNK];
  logic [WIDTH-1:0]  b_d   [0:NCHUNK];
  logic [WIDTH-1:0]  sum_q [0:NCHUNK];
  logic [WIDTH-1:0]  sum_d [0:NCHUNK];
  logic [NCHUNK-1:0] cc_q  [0:NCHUNK];
  logic [NCHUNK-1:0] cc_d  [0:NCHUNK];
  logic [NCHUNK:0]   v_q, v_d;
  logic [NCHUNK-1:0] c_q, c_d;

  logic [CHUNK-1:0]  chunk_s [0:NCHUNK-1];
  logic [NCHUNK-1:0] chunk_co;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !v_q[NCHUNK] || out_ready;
  assign in_ready = adv;

  assign b_eff = (sub == SUB) ? ~b : b;
  assign c0    = (sub == SUB) ? 1'b1 : cIn;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_stage
    chunk_add #(
      .W(CHUNK)
    ) u_chunk (
      .a   (a_q[gi][gi*CHUNK +: CHUNK]),
      .b   (b_q[gi][gi*CHUNK +: CHUNK]),
      .cin (c_q[gi]),
      .s   (chunk_s[gi]),
      .cout(chunk_co[gi])
    );
  end

  always_comb begin
    v_d[0]   = in_valid;
    a_d[0]   = a;
    b_d[0]   = b_eff;
    sum_d[0] = '0;
    cc_d[0]  = '0;
    c_d      = '0;
    c_d[0]   = c0;
    for (int l = 1; l <= NCHUNK; l++) begin
      v_d[l]   = v_q[l-1];
      a_d[l]   = a_q[l-1];
      b_d[l]   = b_q[l-1];
      sum_d[l] = sum_q[l-1];
      sum_d[l][(l-1)*CHUNK +: CHUNK] = chunk_s[l-1];
      cc_d[l]  = cc_q[l-1];
      cc_d[l][l-1] = chunk_co[l-1];
    end
    for (int l = 1; l < NCHUNK; l++) begin
      c_d[l] = chunk_co[l-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int l = 0; l <= NCHUNK; l++) begin
        a_q[l]   <= '0;
        b_q[l]   <= '0;
        sum_q[l] <= '0;
        cc_q[l]  <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      cc_q  <= cc_d;
    end
  end

  assign out_valid   = v_q[NCHUNK];
  assign sum         = sum_q[NCHUNK];
  assign cout_chunks = cc_q[NCHUNK];
  assign carry_out   = cc_q[NCHUNK][NCHUNK-1];
  // Operand MSBs travel with the result so overflow needs no extra stage.
  assign overflow    = (a_q[NCHUNK][MSB] == b_q[NCHUNK][MSB]) &&
                       (sum_q[NCHUNK][MSB] != a_q[NCHUNK][MSB]);

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Scoreboard bench for pipelined_chunk_adder (WIDTH=16, CHUNK=4).
module tb_pipelined_chunk_adder;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cIn = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic [3:0]  cout_chunks;
  logic        carry_out;
  logic        overflow;

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  cc;
    logic        co;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;
  int   retries = 0;
  int   stall_cycles = 0;
  logic hold_prev = 1'b0;
  res_t hold_snap;

  pipelined_chunk_adder #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cIn        (cIn),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout_chunks(cout_chunks),
    .carry_out  (carry_out),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    logic [31:0] ea, eb, t, m;
    logic        c;
    res_t        r;
    ea = {16'h0, ma};
    eb = ms ? {16'h0, ~mb} : {16'h0, mb};
    c  = ms ? 1'b1 : mc;
    for (int k = 0; k < 4; k++) begin
      m = (32'h1 << (4*(k+1))) - 32'h1;
      t = (ea & m) + (eb & m) + {31'h0, c};
      r.cc[k] = t[4*(k+1)];
    end
    t = ea + eb + {31'h0, c};
    r.s   = t[15:0];
    r.co  = t[16];
    r.ovf = (ma[15] == eb[15]) && (r.s[15] != ma[15]);
    return r;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic step(output logic acc);
    res_t got, e;
    @(negedge Clk);
    acc = 1'b0;
    if (!Rst) begin
      got = {sum, cout_chunks, carry_out, overflow};
      if (out_valid && !out_ready) begin
        stall_cycles++;
        check_val("stall_in_ready", {31'h0, in_ready}, 32'h0);
        if (hold_prev) check_val("hold_stable", {10'h0, got}, {10'h0, hold_snap});
        hold_snap = got;
        hold_prev = 1'b1;
      end else begin
        hold_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", {16'h0, sum}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          $display("out %0d: sum=%h cc=%b co=%b ovf=%b", n_out, sum, cout_chunks, carry_out, overflow);
          check_val("result", {10'h0, got}, {10'h0, e});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cIn, sub));
        acc = 1'b1;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
    logic acc;
    logic done;
    a = ia; b = ib; cIn = ic; sub = is; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      step(acc);
      if (acc) done = 1'b1;
      else retries++;
    end
    if (!done) check_val("issue_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    logic acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) step(acc);
    check_val("drain_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    logic acc;
    int   i, cyc;

    // Power-on reset state
    #12;
    check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_sum", {16'h0, sum}, 32'h0);
    check_val("rst_flags", {25'h0, cout_chunks, carry_out, overflow}, 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check_val("rel_in_ready", {31'h0, in_ready}, 32'h1);

    // Reset with three operations in flight
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    issue(16'h3333, 16'h4444, 1'b0, 1'b0);
    issue(16'h5555, 16'h6666, 1'b1, 1'b0);
    Rst = 1'b1;
    #1;
    check_val("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("midrst_sum", {16'h0, sum}, 32'h0);
    check_val("midrst_flags", {25'h0, cout_chunks, carry_out, overflow}, 32'h0);
    exp_q.delete();
    hold_prev = 1'b0;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check_val("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    for (int k = 0; k < 8; k++) step(acc);

    // Directed cases
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    issue(16'h0003, 16'h0005, 1'b0, 1'b1);
    issue(16'h1234, 16'h1234, 1'b1, 1'b1);
    drain();

    // Stream with a three-cycle consumer stall
    i = 0;
    stall_cycles = 0;
    for (cyc = 0; cyc < 40 && i < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid = 1'b1;
      a = i[15:0]; b = 16'h3; cIn = 1'b0; sub = 1'b0;
      step(acc);
      if (acc) i++;
    end
    check_val("stream_accepted", i, 32'd10);
    check_val("stall_cycles", stall_cycles, 32'd3);
    drain();

    // Back-to-back sweep
    retries = 0;
    for (int x = 0; x < 100; x++)
      for (int y = 0; y < 100; y++)
        issue(x[15:0], y[15:0], 1'b0, 1'b0);
    check_val("sweep_retries", retries, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
